// File: rtl/feature_buffer_pkg.sv
// Dimensions, pixel types and FSM encodings shared by the feature buffer,
// the dense consumer and its row/column counter.
package feature_buffer_pkg;

   localparam int FB_OC   = 15;
   localparam int FB_ROWS = 14;
   localparam int FB_COLS = 14;
   localparam int FB_DW   = 8;

   typedef logic signed [FB_DW-1:0]            pixel_t;
   typedef logic signed [0:FB_OC][FB_DW-1:0]   pixel_word_t;

   localparam logic [0:0] ST_FILL = 1'b0;
   localparam logic [0:0] ST_READ = 1'b1;

   // Index width that never collapses to zero bits for degenerate sizes.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/feature_buffer_fmap_mem.sv
// Single-write, dual-lane registered-read storage for one feature map.
// The array itself has no reset; only the read registers do.
module fmap_mem #(
   parameter int DEPTH = 196,
   parameter int AW    = 8,
   parameter int WW    = 128
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [WW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr0,
   input  logic [AW-1:0] i_raddr1,
   input  logic          i_en0,
   input  logic          i_en1,
   output logic [WW-1:0] o_rdata0,
   output logic [WW-1:0] o_rdata1
);

   logic [WW-1:0] r_mem [0:DEPTH-1];
   logic [WW-1:0] r_rdata0;
   logic [WW-1:0] r_rdata1;

   // Storage write port, guarded against addresses past the map.
   always_ff @(posedge clk) begin
      if (i_we && (int'(i_waddr) < DEPTH)) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Read registers: a disabled lane loads zero, an idle read holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else if (i_re) begin
         r_rdata0 <= (i_en0 && (int'(i_raddr0) < DEPTH)) ? r_mem[i_raddr0] : '0;
         r_rdata1 <= (i_en1 && (int'(i_raddr1) < DEPTH)) ? r_mem[i_raddr1] : '0;
      end else begin
         r_rdata0 <= r_rdata0;
         r_rdata1 <= r_rdata1;
      end
   end

   assign o_rdata0 = r_rdata0;
   assign o_rdata1 = r_rdata1;

endmodule

// File: rtl/feature_buffer.sv
// Ping-free feature-map buffer: fills one map in raster order, then serves
// two adjacent pixels per cycle to the dense consumer until it signals done.
module feature_buffer
   import feature_buffer_pkg::*;
#(
   parameter int OC   = FB_OC,
   parameter int ROWS = FB_ROWS,
   parameter int COLS = FB_COLS,
   parameter int DW   = FB_DW
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [0:OC][DW-1:0]      in_data,
   output logic                     in_ready,
   output logic                     dense,
   input  logic [4:0]               row,
   input  logic [4:0]               col,
   input  logic                     done,
   output logic [0:OC][0:1][DW-1:0] dataOut,
   output logic                     err
);

   localparam int RW = idx_width(ROWS);
   localparam int CW = idx_width(COLS);
   localparam int AW = idx_width(ROWS * COLS);
   localparam int WW = (OC + 1) * DW;

   function automatic logic [AW-1:0] calc_addr(input int r, input int c);
      return AW'(r * COLS + c);
   endfunction

   logic [0:0]          r_state;
   logic [RW-1:0]       r_wr_row;
   logic [CW-1:0]       r_wr_col;
   logic                r_in_ready;
   logic                r_dense;
   logic                r_err;

   logic [0:0]          w_next_state;
   logic                w_accept;
   logic                w_last_col;
   logic                w_last_word;
   logic                w_read;
   logic                w_row_ok;
   logic                w_col_ok;
   logic                w_col1_ok;
   logic                w_en0;
   logic                w_en1;
   logic [AW-1:0]       w_wr_addr;
   logic [AW-1:0]       w_rd_addr0;
   logic [AW-1:0]       w_rd_addr1;
   logic [0:OC][DW-1:0] w_lane0;
   logic [0:OC][DW-1:0] w_lane1;

   // in_ready is only ever high in FILL, so it alone qualifies a write.
   assign w_accept    = r_in_ready && in_valid && (r_state == ST_FILL);
   assign w_last_col  = (r_wr_col == CW'(COLS - 1));
   assign w_last_word = w_last_col && (r_wr_row == RW'(ROWS - 1));
   assign w_read      = (r_state == ST_READ);

   assign w_row_ok    = (int'(row) < ROWS);
   assign w_col_ok    = (int'(col) < COLS);
   assign w_col1_ok   = ((int'(col) + 1) < COLS);
   assign w_en0       = w_row_ok && w_col_ok;
   assign w_en1       = w_en0 && w_col1_ok;

   assign w_wr_addr   = calc_addr(int'(r_wr_row), int'(r_wr_col));
   assign w_rd_addr0  = calc_addr(int'(row), int'(col));
   assign w_rd_addr1  = calc_addr(int'(row), int'(col) + 1);

   // Next-state decode for the FILL/READ sequencer.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_FILL: begin
            if (w_accept && w_last_word) begin
               w_next_state = ST_READ;
            end else begin
               w_next_state = ST_FILL;
            end
         end
         ST_READ: begin
            if (done) begin
               w_next_state = ST_FILL;
            end else begin
               w_next_state = ST_READ;
            end
         end
         default: begin
            w_next_state = ST_FILL;
         end
      endcase
   end

   // State plus the registered handshake outputs that follow it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_FILL;
         r_in_ready <= 1'b0;
         r_dense    <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_in_ready <= (w_next_state == ST_FILL);
         r_dense    <= (w_next_state == ST_READ);
      end
   end

   // Raster-order write pointer; done rewinds it for the next pass.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_row <= '0;
         r_wr_col <= '0;
      end else if (w_read && done) begin
         r_wr_row <= '0;
         r_wr_col <= '0;
      end else if (w_accept) begin
         if (w_last_word) begin
            r_wr_row <= '0;
            r_wr_col <= '0;
         end else if (w_last_col) begin
            r_wr_row <= r_wr_row + RW'(1);
            r_wr_col <= '0;
         end else begin
            r_wr_col <= r_wr_col + CW'(1);
         end
      end
   end

   // Sticky protocol error: out-of-map read or done outside READ.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err <= 1'b0;
      end else if (w_read && !w_en0) begin
         r_err <= 1'b1;
      end else if ((r_state == ST_FILL) && done) begin
         r_err <= 1'b1;
      end else begin
         r_err <= r_err;
      end
   end

   fmap_mem #(
      .DEPTH (ROWS * COLS),
      .AW    (AW),
      .WW    (WW)
   ) u_fmap_mem (
      .clk      (clk),
      .rst_n    (rst),
      .i_we     (w_accept),
      .i_waddr  (w_wr_addr),
      .i_wdata  (in_data),
      .i_re     (w_read),
      .i_raddr0 (w_rd_addr0),
      .i_raddr1 (w_rd_addr1),
      .i_en0    (w_en0),
      .i_en1    (w_en1),
      .o_rdata0 (w_lane0),
      .o_rdata1 (w_lane1)
   );

   // Regroup the two registered lanes into per-channel pairs.
   always_comb begin
      dataOut = '0;
      for (int k = 0; k <= OC; k++) begin
         dataOut[k][0] = w_lane0[k];
         dataOut[k][1] = w_lane1[k];
      end
   end

   assign in_ready = r_in_ready;
   assign dense    = r_dense;
   assign err      = r_err;

endmodule

// File: tb/tb_feature_buffer.sv
// Directed bench for feature_buffer: fills, reads, boundaries, done handling, resets.
module tb_feature_buffer;
   import feature_buffer_pkg::*;

   logic                clk;
   logic                rst;
   logic                in_valid;
   pixel_word_t         in_data;
   logic                in_ready;
   logic                dense;
   logic [4:0]          row;
   logic [4:0]          col;
   logic                done;
   logic [0:15][0:1][7:0] dataOut;
   logic                err;

   int n_tests = 0;
   int n_fail  = 0;

   feature_buffer dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .dense    (dense),
      .row      (row),
      .col      (col),
      .done     (done),
      .dataOut  (dataOut),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input int r, input int c);
      row = 5'(r);
      col = 5'(c);
      tick();
   endtask

   task automatic pulse_done();
      done = 1'b1;
      tick();
      done = 1'b0;
   endtask

   task automatic drive_word(input int idx, input int base);
      in_valid = 1'b1;
      for (int k = 0; k < 16; k++) begin
         in_data[k] = 8'(((idx + base) % 128) + k);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; in_valid = 1'b0; in_data = '0; row = '0; col = '0; done = 1'b0;
      repeat (2) tick();
      n_tests++;
      if (in_ready !== 1'b0 || dense !== 1'b0 || err !== 1'b0 || dataOut !== '0) begin
         n_fail++;
         $display("FAIL reset_state: in_ready=%b dense=%b err=%b dataOut_zero=%b, expected 0 0 0 1",
                  in_ready, dense, err, dataOut == '0);
      end
      rst = 1'b1;
      tick();
      n_tests++;
      if (in_ready !== 1'b1 || dense !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: in_ready=%b dense=%b, expected 1 0", in_ready, dense);
      end
   endtask

   task automatic test_fill(input int base, input bit gap, input string name);
      int early = 0;
      for (int i = 0; i < 196; i++) begin
         if (gap) begin
            in_valid = 1'b0;
            repeat (2) tick();
            if (dense !== 1'b0) early++;
         end
         drive_word(i, base);
         tick();
         if (i < 195 && dense !== 1'b0) early++;
      end
      in_valid = 1'b0;
      n_tests++;
      if (early !== 0) begin
         n_fail++;
         $display("FAIL %s_early: dense high in %0d cycles before word 196, expected 0", name, early);
      end
      n_tests++;
      if (dense !== 1'b1 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_to_read: dense=%b in_ready=%b, expected 1 0", name, dense, in_ready);
      end
   endtask

   task automatic test_read_pattern();
      do_read(3, 4);
      for (int k = 0; k < 16; k++) begin
         n_tests++;
         if (dataOut[k][0] !== 8'(46 + k) || dataOut[k][1] !== 8'(47 + k)) begin
            n_fail++;
            $display("FAIL read_3_4 ch%0d: got %0d/%0d expected %0d/%0d",
                     k, dataOut[k][0], dataOut[k][1], 46 + k, 47 + k);
         end
      end
      n_tests++;
      if (dataOut[5][0] !== 8'd51 || dataOut[5][1] !== 8'd52) begin
         n_fail++;
         $display("FAIL read_3_4_ch5: got %0d/%0d expected 51/52", dataOut[5][0], dataOut[5][1]);
      end
   endtask

   task automatic test_read_ignores_valid();
      in_valid = 1'b1;
      for (int k = 0; k < 16; k++) in_data[k] = 8'h55;
      row = 5'd0; col = 5'd0;
      for (int n = 0; n < 4; n++) begin
         tick();
         n_tests++;
         if (in_ready !== 1'b0 || dataOut[0][0] !== 8'd0 || dataOut[0][1] !== 8'd1
             || dataOut[15][0] !== 8'd15 || dataOut[15][1] !== 8'd16) begin
            n_fail++;
            $display("FAIL read_hold_valid cyc%0d: in_ready=%b ch0=%0d/%0d ch15=%0d/%0d expected 0 0/1 15/16",
                     n, in_ready, dataOut[0][0], dataOut[0][1], dataOut[15][0], dataOut[15][1]);
         end
      end
      in_valid = 1'b0;
      do_read(0, 0);
      n_tests++;
      if (dataOut[3][0] !== 8'd3 || dataOut[3][1] !== 8'd4) begin
         n_fail++;
         $display("FAIL reread_0_0: ch3=%0d/%0d expected 3/4", dataOut[3][0], dataOut[3][1]);
      end
   endtask

   task automatic test_boundary();
      do_read(3, 13);
      for (int k = 0; k < 16; k++) begin
         n_tests++;
         if (dataOut[k][0] !== 8'(55 + k) || dataOut[k][1] !== 8'd0) begin
            n_fail++;
            $display("FAIL read_col13 ch%0d: got %0d/%0d expected %0d/0",
                     k, dataOut[k][0], dataOut[k][1], 55 + k);
         end
      end
      n_tests++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL err_col13: err=%b expected 0", err);
      end
      do_read(14, 0);
      n_tests++;
      if (dataOut !== '0 || err !== 1'b1) begin
         n_fail++;
         $display("FAIL read_row14: dataOut_zero=%b err=%b expected 1 1", dataOut == '0, err);
      end
   endtask

   task automatic test_done_and_refill();
      row = 5'd5; col = 5'd2;
      pulse_done();
      n_tests++;
      if (dense !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL done_to_fill: dense=%b in_ready=%b expected 0 1", dense, in_ready);
      end
      row = 5'd0; col = 5'd0;
      repeat (3) tick();
      n_tests++;
      if (dataOut[0][0] !== 8'd72 || dataOut[0][1] !== 8'd73 || dataOut[9][0] !== 8'd81) begin
         n_fail++;
         $display("FAIL fill_holds_out: ch0=%0d/%0d ch9=%0d expected 72/73 81",
                  dataOut[0][0], dataOut[0][1], dataOut[9][0]);
      end
      test_fill(7, 1'b1, "gap_fill");
      do_read(0, 0);
      n_tests++;
      if (dataOut[0][0] !== 8'd7 || dataOut[0][1] !== 8'd8 || dataOut[15][0] !== 8'd22) begin
         n_fail++;
         $display("FAIL refill_0_0: ch0=%0d/%0d ch15=%0d expected 7/8 22",
                  dataOut[0][0], dataOut[0][1], dataOut[15][0]);
      end
      do_read(13, 12);
      n_tests++;
      if (dataOut[0][0] !== 8'd73 || dataOut[0][1] !== 8'd74 || dataOut[2][1] !== 8'd76) begin
         n_fail++;
         $display("FAIL refill_13_12: ch0=%0d/%0d ch2_l1=%0d expected 73/74 76",
                  dataOut[0][0], dataOut[0][1], dataOut[2][1]);
      end
      pulse_done();
   endtask

   task automatic test_reset_midfill();
      for (int i = 0; i < 100; i++) begin
         drive_word(i, 3);
         tick();
      end
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      n_tests++;
      if (in_ready !== 1'b0 || dense !== 1'b0 || err !== 1'b0 || dataOut !== '0) begin
         n_fail++;
         $display("FAIL midfill_reset: in_ready=%b dense=%b err=%b dataOut_zero=%b expected 0 0 0 1",
                  in_ready, dense, err, dataOut == '0);
      end
      repeat (2) tick();
      rst = 1'b1;
      tick();
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midfill_release: in_ready=%b expected 1", in_ready);
      end
      test_fill(11, 1'b0, "post_reset_fill");
      do_read(0, 0);
      n_tests++;
      if (dataOut[0][0] !== 8'd11 || dataOut[0][1] !== 8'd12 || dataOut[4][1] !== 8'd16) begin
         n_fail++;
         $display("FAIL post_reset_0_0: ch0=%0d/%0d ch4_l1=%0d expected 11/12 16",
                  dataOut[0][0], dataOut[0][1], dataOut[4][1]);
      end
      pulse_done();
      n_tests++;
      if (err !== 1'b0 || dense !== 1'b0) begin
         n_fail++;
         $display("FAIL legal_done: err=%b dense=%b expected 0 0", err, dense);
      end
   endtask

   task automatic test_done_in_fill();
      pulse_done();
      tick();
      n_tests++;
      if (err !== 1'b1 || dense !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL done_in_fill: err=%b dense=%b in_ready=%b expected 1 0 1", err, dense, in_ready);
      end
   endtask

   initial begin
      test_reset();
      test_fill(0, 1'b0, "first_fill");
      test_read_pattern();
      test_read_ignores_valid();
      test_boundary();
      test_done_and_refill();
      test_reset_midfill();
      test_done_in_fill();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/feature_buffer.md
FEATURE_BUFFER -- requirements
Module: feature_buffer

Interface
REQ-001 Parameter OC, default 15: highest channel index; the block handles OC+1 channels.
REQ-002 Parameter ROWS, default 14: feature-map rows.
REQ-003 Parameter COLS, default 14: feature-map columns.
REQ-004 Parameter DW, default 8: signed pixel width.
REQ-005 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous and active-low.
REQ-007 Port in_valid, input, 1: the upstream pixel word is valid.
REQ-008 Port in_data, input, [0:OC] x DW signed: one pixel position, all channels, raster order.
REQ-009 Port in_ready, output, 1: the buffer accepts in_data this cycle.
REQ-010 Port dense, output, 1: the read phase is active; drives the dense consumer's start/hold input.
REQ-011 Port row, input, 5: read row from the consumer's counter.
REQ-012 Port col, input, 5: read column (even) from the consumer's counter.
REQ-013 Port done, input, 1: the consumer has finished the pass (one-cycle pulse).
REQ-014 Port dataOut, output, [0:OC][0:1] x DW signed: pixel (row,col) in lane 0 and pixel (row,col+1) in lane 1, per channel.
REQ-015 Port err, output, 1: sticky flag for a protocol violation.

Function
REQ-016 Two states: FILL and READ; the reset state is FILL.
REQ-017 In FILL, in_ready=1 and dense=0; a word is written when in_valid=1 at (wr_row, wr_col).
REQ-018 The write pointer advances in raster order: wr_col wraps at COLS-1 to 0 and increments wr_row.
REQ-019 Acceptance of the word at (ROWS-1, COLS-1) moves the block to READ on the same edge; dense=1 from the next cycle.
REQ-020 In READ, in_ready=0 and incoming in_valid is ignored; no write occurs.
REQ-021 In READ, dataOut is registered from (row, col) with one-cycle latency, aligned with a consumer that delays its own dense by one cycle.
REQ-022 If col+1 >= COLS, lane 1 outputs 0; if row >= ROWS or col >= COLS, both lanes output 0 and err is set.
REQ-023 done=1 in READ returns the block to FILL and clears the write pointers to (0,0); dense=0 from the next cycle; the stored data is retained until overwritten.
REQ-024 done=1 in FILL is ignored and sets err.
REQ-025 In FILL, dataOut holds its last value; stored data is never read in FILL.
REQ-026 No arithmetic is performed on pixel data; indices are unsigned and the address is row*COLS+col, sized to hold ROWS*COLS-1.

Reset
REQ-027 While rst=0: state=FILL, write pointers=0, dense=0, in_ready=0, err=0, dataOut all lanes=0.
REQ-028 in_ready rises to 1 on the first edge after rst is released.
REQ-029 Reset mid-fill or mid-read abandons the pass; the memory contents are not cleared and are undefined to users.

Structure
REQ-030 A shared package holds OC, ROWS, COLS, DW and the pixel-word type, shared with the dense consumer and the counter.
REQ-031 One sub-module, fmap_mem: a dual-lane-read, single-write storage array, registered read, no reset on the array.
REQ-032 The FSM and the write pointers reside in feature_buffer.

Verification
REQ-033 Fill 196 words with value (r*14+c) mod 128 on channel k plus k -> after the last word, dense=1 next cycle, in_ready=0.
REQ-034 In READ, row=3, col=4 -> the next cycle, channel 0 lanes = 46 and 47, and channel 5 lanes = 51 and 52.
REQ-035 Read col=13 -> lane 1 = 0 on all channels; read row=14 -> both lanes 0 and err=1.
REQ-036 in_valid held during READ -> memory unchanged (re-read of (0,0) is unchanged); then a done pulse -> dense=0 next cycle, in_ready=1, and a new fill starts at (0,0).
REQ-037 Fill with in_valid gapped (1 of 3 cycles) -> the READ transition occurs only after exactly 196 accepted words.
REQ-038 Assert rst at word 100 -> all outputs reset; after release, a full 196-word fill is again required before dense=1.
